// File: rtl/uart_aes_cmd_ctrl_if.sv
// uart_aes_cmd_ctrl_if: receive-buffer, transmitter and AES-core signals seen by the command controller
interface uart_aes_cmd_ctrl_if #(
    parameter int FRAME_BYTES = 18
);
    logic                       frame_valid;
    logic [8*FRAME_BYTES-1:0]   frame_in;
    logic                       frame_rd;
    logic                       tx_busy;
    logic                       tx_trigger;
    logic [8*FRAME_BYTES-1:0]   tx_frame;
    logic [127:0]               aes_key;
    logic [127:0]               aes_text;
    logic                       aes_ld;
    logic                       aes_done;
    logic [127:0]               aes_result;

    modport master (
        input  frame_valid, frame_in, tx_busy, aes_done, aes_result,
        output frame_rd, tx_trigger, tx_frame, aes_key, aes_text, aes_ld
    );

    modport slave (
        output frame_valid, frame_in, tx_busy, aes_done, aes_result,
        input  frame_rd, tx_trigger, tx_frame, aes_key, aes_text, aes_ld
    );
endinterface

// File: rtl/uart_aes_cmd_ctrl.sv
// uart_aes_cmd_ctrl: decodes UART command frames, drives the AES core and builds reply frames
module uart_aes_cmd_ctrl #(
    parameter int           FRAME_BYTES = 18,
    parameter logic [127:0] KEY_INIT    = 128'h0,
    parameter logic [127:0] TEXT_INIT   = 128'h0,
    parameter int           AES_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_aes_cmd_ctrl_if.master    bus,
    output logic                   result_valid,
    output logic [7:0]             err_count
);
    localparam int W  = 8 * FRAME_BYTES;
    localparam int CW = $clog2(AES_TIMEOUT + 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] DECODE   = 3'd1;
    localparam logic [2:0] AES_WAIT = 3'd2;
    localparam logic [2:0] TX_SEND  = 3'd3;
    localparam logic [2:0] TX_HOLD  = 3'd4;

    logic [2:0]    state;
    logic [W-1:0]  frame;
    logic [127:0]  result;
    logic [CW-1:0] cnt;
    logic [7:0]    op;

    assign op = frame[7:0];

    // Pop the head frame in the same IDLE cycle it is latched; never while reset holds the FSM
    assign bus.frame_rd = !reset && state == IDLE && bus.frame_valid;

    // Command FSM: latch, decode, run AES with timeout, hand the reply to the transmitter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            frame          <= '0;
            result         <= '0;
            cnt            <= '0;
            result_valid   <= 1'b0;
            err_count      <= 8'd0;
            bus.tx_trigger <= 1'b0;
            bus.tx_frame   <= '0;
            bus.aes_key    <= KEY_INIT;
            bus.aes_text   <= TEXT_INIT;
            bus.aes_ld     <= 1'b0;
        end else begin
            bus.tx_trigger <= 1'b0;
            bus.aes_ld     <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        frame <= bus.frame_in;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state <= TX_SEND;
                    if (frame[W-1 -: 8] != op) begin
                        err_count    <= (err_count == 8'hff) ? err_count : err_count + 8'd1;
                        bus.tx_frame <= W'("ERR");
                    end else begin
                        case (op)
                            8'h41: bus.tx_frame <= W'("123456789012345678");
                            8'h43: begin
                                bus.aes_key  <= frame[8 +: 128];
                                bus.tx_frame <= W'("key updated");
                            end
                            8'h44: begin
                                bus.aes_text <= frame[8 +: 128];
                                bus.tx_frame <= W'("plaintext updated");
                            end
                            8'h45: begin
                                bus.aes_ld <= 1'b1;
                                cnt        <= '0;
                                state      <= AES_WAIT;
                            end
                            8'h40:   bus.tx_frame <= W'(result);
                            8'h61:   bus.tx_frame <= W'(bus.aes_key);
                            8'h62:   bus.tx_frame <= W'(bus.aes_text);
                            default: bus.tx_frame <= W'("?");
                        endcase
                    end
                end
                AES_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (bus.aes_done && !bus.aes_ld) begin
                        result       <= bus.aes_result;
                        result_valid <= 1'b1;
                        state        <= IDLE;
                    end else if (cnt == CW'(AES_TIMEOUT - 2)) begin
                        bus.tx_frame <= W'("TIMEOUT");
                        state        <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (!bus.tx_busy) begin
                        bus.tx_trigger <= 1'b1;
                        state          <= TX_HOLD;
                    end
                end
                TX_HOLD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_aes_cmd_ctrl.sv
// tb_uart_aes_cmd_ctrl: scoreboard bench with receive buffer, transmitter and AES stand-ins
module tb_uart_aes_cmd_ctrl;
    localparam int W           = 144;
    localparam int AES_TIMEOUT = 1024;
    localparam int AES_LAT     = 20;
    localparam logic [127:0] PT = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
    localparam logic [127:0] CT = 128'h0336763e966d92595a567cc9ce537f5e;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       result_valid;
    logic [7:0] err_count;

    uart_aes_cmd_ctrl_if #(.FRAME_BYTES(18)) bus ();

    uart_aes_cmd_ctrl #(
        .FRAME_BYTES(18), .KEY_INIT(128'h0), .TEXT_INIT(128'h0), .AES_TIMEOUT(AES_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .result_valid(result_valid), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, pop_cyc = 0, trig_cyc = 0, ld_cyc = 0;
    int n_pop = 0, n_trig = 0, n_ld = 0, exp_ld = 0;
    logic [W-1:0] rx_q[$];
    logic [W-1:0] exp_q[$];
    logic [127:0] m_key = '0, m_text = '0, m_res = '0;
    logic         m_rv = 1'b0;
    logic [7:0]   m_err = 8'd0;
    bit aes_en = 1'b1, force_busy = 1'b0;
    int busy_cnt = 0, aes_cnt = 0;
    logic [127:0] aes_k = '0, aes_t = '0;
    logic prev_trig = 1'b0, prev_rd = 1'b0, prev_ld = 1'b0, busy_prev = 1'b0;

    function automatic void check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [127:0] fake_aes(input logic [127:0] k, input logic [127:0] t);
        return (k == '0 && t == PT) ? CT : {k[63:0], k[127:64]} ^ t ^ {4{32'h5a5a5a5a}};
    endfunction

    // Reference model: what one frame should produce, applied in arrival order
    function automatic void model(input logic [7:0] hdr, input logic [127:0] pl, input logic [7:0] trl);
        if (hdr != trl) begin
            m_err = (m_err == 8'd255) ? m_err : m_err + 8'd1;
            exp_q.push_back(W'("ERR"));
        end else begin
            case (trl)
                "A": exp_q.push_back(W'("123456789012345678"));
                "C": begin m_key = pl; exp_q.push_back(W'("key updated")); end
                "D": begin m_text = pl; exp_q.push_back(W'("plaintext updated")); end
                "E": begin
                    exp_ld++;
                    if (aes_en) begin m_res = fake_aes(m_key, m_text); m_rv = 1'b1; end
                    else exp_q.push_back(W'("TIMEOUT"));
                end
                "@": exp_q.push_back(W'(m_res));
                "a": exp_q.push_back(W'(m_key));
                "b": exp_q.push_back(W'(m_text));
                default: exp_q.push_back(W'("?"));
            endcase
        end
    endfunction

    // Receive buffer: pops on frame_rd, presents the head frame
    always @(posedge clk) begin
        if (bus.frame_rd && rx_q.size() != 0) void'(rx_q.pop_front());
        #1;
        bus.frame_valid = rx_q.size() != 0;
        bus.frame_in    = rx_q.size() != 0 ? rx_q[0] : '0;
    end

    // Transmitter: busy for a few cycles after each trigger, or while forced
    always @(posedge clk) begin
        #1;
        if (bus.tx_trigger) busy_cnt = 4;
        else if (busy_cnt != 0) busy_cnt--;
        bus.tx_busy = force_busy || busy_cnt != 0;
    end

    // AES core: result AES_LAT cycles after aes_ld, garbage on aes_result otherwise
    always @(posedge clk) begin
        #1;
        cyc++;
        bus.aes_done   = 1'b0;
        bus.aes_result = {$urandom(), $urandom(), $urandom(), $urandom()};
        if (bus.aes_ld && aes_en) begin
            aes_cnt = AES_LAT;
            aes_k   = bus.aes_key;
            aes_t   = bus.aes_text;
        end else if (aes_cnt != 0) begin
            aes_cnt--;
            if (aes_cnt == 0) begin
                bus.aes_done   = 1'b1;
                bus.aes_result = fake_aes(aes_k, aes_t);
            end
        end
    end

    // Monitor: scoreboard on every trigger, single-cycle pulse checks
    always @(negedge clk) begin
        if (bus.tx_trigger) begin
            check("trigger_pulse", W'(prev_trig), '0);
            check("trigger_while_idle_tx", W'(busy_prev), '0);
            check("reply_expected", W'(exp_q.size() != 0), W'(1));
            if (exp_q.size() != 0) check("reply_frame", bus.tx_frame, exp_q.pop_front());
            n_trig++;
            trig_cyc = cyc;
        end
        if (bus.frame_rd) begin
            check("frame_rd_pulse", W'(prev_rd), '0);
            n_pop++;
            pop_cyc = cyc;
        end
        if (bus.aes_ld) begin
            check("aes_ld_pulse", W'(prev_ld), '0);
            n_ld++;
            ld_cyc = cyc;
        end
        prev_trig = bus.tx_trigger;
        prev_rd   = bus.frame_rd;
        prev_ld   = bus.aes_ld;
        busy_prev = bus.tx_busy;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] hdr, input logic [127:0] pl, input logic [7:0] trl);
        rx_q.push_back({hdr, pl, trl});
        model(hdr, pl, trl);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0 || aes_cnt != 0) && k < budget) begin
            tick();
            k++;
        end
        check("drain_within_budget", W'(k < budget), W'(1));
        tick(AES_LAT + 10);
    endtask

    task automatic check_reset_values(input string tag);
        @(negedge clk);
        check({tag, "_frame_rd"}, W'(bus.frame_rd), '0);
        check({tag, "_tx_trigger"}, W'(bus.tx_trigger), '0);
        check({tag, "_aes_ld"}, W'(bus.aes_ld), '0);
        check({tag, "_tx_frame"}, bus.tx_frame, '0);
        check({tag, "_aes_key"}, W'(bus.aes_key), '0);
        check({tag, "_aes_text"}, W'(bus.aes_text), '0);
        check({tag, "_result_valid"}, W'(result_valid), '0);
        check({tag, "_err_count"}, W'(err_count), '0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [8] = '{"A", "C", "D", "E", "@", "a", "b", "Z"};
        logic [7:0] h, t;
        int t0, p0, k;
        reset = 1'b1;
        tick(3);
        check_reset_values("reset");
        reset = 1'b0;
        tick(2);

        send("C", 128'h000102030405060708090a0b0c0d0e0f, "C");
        drain(200);
        check("key_load", W'(bus.aes_key), W'(128'h000102030405060708090a0b0c0d0e0f));
        check("reply_latency", W'(trig_cyc - pop_cyc), W'(3));

        send("C", '0, "C");
        send("D", PT, "D");
        send("E", '0, "E");
        drain(300);
        check("aes_ld_count", W'(n_ld), W'(exp_ld));
        check("result_valid_set", W'(result_valid), W'(1));
        send("@", rnd128(), "@");
        drain(200);

        send("C", rnd128(), "D");
        drain(200);
        check("bad_frame_err", W'(err_count), W'(1));
        check("bad_frame_key_kept", W'(bus.aes_key), W'(m_key));
        repeat (300) begin
            h = 8'($urandom());
            t = h ^ 8'($urandom_range(1, 255));
            send(h, rnd128(), t);
        end
        drain(6000);
        check("err_saturate", W'(err_count), W'(m_err));

        send("E", '0, "E");
        k = 0;
        t0 = n_ld;
        while (n_ld == t0 && k < 50) begin tick(); k++; end
        check("ld_before_reset", W'(n_ld), W'(t0 + 1));
        tick(5);
        reset = 1'b1;
        check_reset_values("mid_reset");
        m_key = '0; m_text = '0; m_res = '0; m_rv = 1'b0; m_err = 8'd0;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        k = 0;
        while (aes_cnt != 0 && k < 50) begin tick(); k++; end
        tick(3);
        check("late_done_ignored", W'(result_valid), '0);
        send("Z", rnd128(), "Z");
        send("@", rnd128(), "@");
        drain(200);

        aes_en = 1'b0;
        send("E", '0, "E");
        drain(1500);
        check("timeout_latency", W'(trig_cyc - ld_cyc), W'(AES_TIMEOUT));
        check("timeout_result_valid", W'(result_valid), W'(m_rv));
        aes_en = 1'b1;

        force_busy = 1'b1;
        tick(3);
        t0 = n_trig;
        p0 = n_pop;
        repeat (3) send("A", rnd128(), "A");
        tick(50);
        check("no_trigger_while_busy", W'(n_trig), W'(t0));
        force_busy = 1'b0;
        drain(300);
        check("busy_triggers", W'(n_trig), W'(t0 + 3));
        check("busy_pops", W'(n_pop), W'(p0 + 3));

        repeat (200) begin
            t = ops[$urandom_range(0, 7)];
            h = ($urandom_range(0, 7) == 0) ? t ^ 8'h20 : t;
            send(h, rnd128(), t);
        end
        drain(20000);
        check("rand_key", W'(bus.aes_key), W'(m_key));
        check("rand_text", W'(bus.aes_text), W'(m_text));
        check("rand_result_valid", W'(result_valid), W'(m_rv));
        check("rand_err_count", W'(err_count), W'(m_err));
        check("rand_ld_count", W'(n_ld), W'(exp_ld));
        send("@", rnd128(), "@");
        drain(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
